// File: rtl/counter_nbit_updn.sv
// rtl/counter_nbit_updn.sv - N-bit up/down modulo counter with wrap/saturate and terminal count
// Optional sticky overflow flag (ports ovf_clr/ovf) enabled by defining CNT_OVF_STICKY_EN.
module counter_nbit_updn #(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 16,
  parameter int SAT_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
`ifdef CNT_OVF_STICKY_EN
  input  logic             ovf_clr,
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULO - 1);
  localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);
  localparam bit             SAT     = (SAT_MODE != 0);

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] next_ext;
  logic [WIDTH:0] load_ext;
  logic           at_top;
  logic           at_bot;

  assign cnt_ext = {1'b0, count};
  assign at_top  = (cnt_ext == MAX_EXT);
  assign at_bot  = (count == '0);

  // tc doubles as the end-of-range event when counting proceeds this cycle
  assign tc = en & ((up_dn & at_top) | (~up_dn & at_bot));

  always_comb begin
    next_ext = cnt_ext;
    if (up_dn) begin
      if (at_top) next_ext = SAT ? MAX_EXT : '0;
      else        next_ext = cnt_ext + ONE_EXT;
    end else begin
      if (at_bot) next_ext = SAT ? '0 : MAX_EXT;
      else        next_ext = cnt_ext - ONE_EXT;
    end
  end

  always_comb begin
    load_ext = {1'b0, load_val};
    if (load_ext > MAX_EXT) load_ext = MAX_EXT;
  end

  logic unused_msb;
  assign unused_msb = &{1'b0, next_ext[WIDTH], load_ext[WIDTH]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_ext[WIDTH-1:0];
      wrap  <= 1'b0;
    end else if (en) begin
      count <= next_ext[WIDTH-1:0];
      wrap  <= tc;
    end else begin
      wrap  <= 1'b0;
    end
  end

`ifdef CNT_OVF_STICKY_EN
  // a same-cycle event beats ovf_clr
  always_ff @(posedge clk) begin
    if (!rst_n)                 ovf <= 1'b0;
    else if (clr)               ovf <= 1'b0;
    else if (!load && tc)       ovf <= 1'b1;
    else if (ovf_clr)           ovf <= 1'b0;
  end
`endif

endmodule
